pipe_stage_skid: RTL and testbench

- Parametrised pipeline-stage register with a valid/ready handshake. It replaces the fixed-width, always-enabled stage latches placed between pipeline stages.
- Holds up to two entries: a main output entry plus one skid entry. Upstream ready is therefore fully registered, and stall back-pressure never forms a combinational path.
- Control bits are squashed to zero whenever the stage carries a bubble. A synchronous flush kills everything in flight.

---
 rtl/pipe_stage_skid.sv | 133 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, one skid entry and a registered in_ready.
// Define PIPE_STAGE_PERF_CNT_EN to add the saturating bubble_cnt and stall_cnt outputs.
module pipe_stage_skid #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              acc, pop;
  logic              load_main_in, load_main_skid, load_skid;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // State register; in_ready is a flop so back-pressure never forms a combinational path.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != TWO);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        state_next   = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (acc && pop) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: if (pop) begin
        state_next     = ONE;
        load_main_skid = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
    // Flush overrides everything, including an accept in the same cycle.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // NOTE: the datapath registers are reset on purpose: reset values of out_data are observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end else if (load_main_skid || flush) begin
        skid_ctrl <= '0;
      end
    end
  end

  // Outputs decoded from state; control is squashed on bubbles, payload is not.
  always_comb begin
    out_valid = (state != EMPTY);
    out_data  = main_data;
    out_ctrl  = out_valid ? main_ctrl : '0;
    occupancy = state;
  end

  occupancy_in_range: assert property (@(posedge clk) disable iff (!rst_n) occupancy != 2'd3);

`ifdef PIPE_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!out_valid && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: reset, streaming, stall/skid, flush, async reset.
// Counter scenarios run only when PIPE_STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [15:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [15:0] bubble_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (out_ctrl !== 8'h0) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=00", out_ctrl); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_before_edge_in_ready got=%0b exp=0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_edge_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL idle_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 1); in_ctrl = 8'(8'h10 + i);
      if (i == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency_pre got=%0b exp=0", out_valid); end
      end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'(i + 1) || out_ctrl !== 8'(8'h10 + i))
        begin errors++; $display("FAIL stream_out[%0d] got v=%0b d=%h c=%h exp v=1 d=%h c=%h", i, out_valid, out_data, out_ctrl, 16'(i + 1), 8'(8'h10 + i)); end
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1)
        begin errors++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b exp occ=1 rdy=1", i, occupancy, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h0 || occupancy !== 2'd0 || out_data !== 16'h0008)
      begin errors++; $display("FAIL stream_drain got v=%0b c=%h occ=%0d d=%h exp v=0 c=00 occ=0 d=0008", out_valid, out_ctrl, occupancy, out_data); end
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A1; in_ctrl = 8'hA1;
    step();
    checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 16'h00A1)
      begin errors++; $display("FAIL stall_first got occ=%0d rdy=%0b d=%h exp occ=1 rdy=1 d=00a1", occupancy, in_ready, out_data); end
    in_data = 16'h00A2; in_ctrl = 8'hA2;
    step();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h00A1 || out_ctrl !== 8'hA1)
      begin errors++; $display("FAIL stall_two got occ=%0d rdy=%0b d=%h c=%h exp occ=2 rdy=0 d=00a1 c=a1", occupancy, in_ready, out_data, out_ctrl); end
    in_data = 16'h00A3; in_ctrl = 8'hA3;
    step();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h00A1)
      begin errors++; $display("FAIL stall_hold got occ=%0d rdy=%0b v=%0b d=%h exp occ=2 rdy=0 v=1 d=00a1", occupancy, in_ready, out_valid, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 16'h00A2 || out_ctrl !== 8'hA2)
      begin errors++; $display("FAIL skid_drain got occ=%0d rdy=%0b d=%h c=%h exp occ=1 rdy=1 d=00a2 c=a2", occupancy, in_ready, out_data, out_ctrl); end
    step();
    checks++; if (occupancy !== 2'd1 || out_data !== 16'h00A3 || out_ctrl !== 8'hA3)
      begin errors++; $display("FAIL third_accept got occ=%0d d=%h c=%h exp occ=1 d=00a3 c=a3", occupancy, out_data, out_ctrl); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin errors++; $display("FAIL stall_empty got v=%0b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_ctrl = 8'hFF;
    in_valid = 1'b1; in_data = 16'h00B1; step();
    in_data = 16'h00B2; step();
    checks++; if (occupancy !== 2'd2 || out_ctrl !== 8'hFF)
      begin errors++; $display("FAIL flush_fill got occ=%0d c=%h exp occ=2 c=ff", occupancy, out_ctrl); end
    flush = 1'b1; in_data = 16'h00C3;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_two got v=%0b c=%h occ=%0d rdy=%0b exp v=0 c=00 occ=0 rdy=1", out_valid, out_ctrl, occupancy, in_ready); end
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got v=%0b exp=0", out_valid); end
    // Flush while in_ready=1: the coincident accept must be discarded.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00D1; in_ctrl = 8'h5A;
    step();
    flush = 1'b1; in_data = 16'h00D2;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 8'h00)
      begin errors++; $display("FAIL flush_acc got v=%0b occ=%0d c=%h exp v=0 occ=0 c=00", out_valid, occupancy, out_ctrl); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_acc_ghost got v=%0b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h77;
    in_data = 16'h00E1; step();
    in_data = 16'h00E2; step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL async_fill got occ=%0d exp=2", occupancy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_ctrl !== 8'h0 || occupancy !== 2'd0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL async_reset got v=%0b d=%h c=%h occ=%0d rdy=%0b exp all 0", out_valid, out_data, out_ctrl, occupancy, in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL async_release got v=%0b occ=%0d rdy=%0b exp v=0 occ=0 rdy=1", out_valid, occupancy, in_ready); end
  endtask

`ifdef PIPE_STAGE_PERF_CNT_EN
  task automatic test_perf_cnt();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) step();
    in_valid = 1'b1; in_data = 16'h0F0F; in_ctrl = 8'h01;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (bubble_cnt !== 16'd5 || stall_cnt !== 16'd3)
      begin errors++; $display("FAIL perf_counts got bub=%0d stall=%0d exp bub=5 stall=3", bubble_cnt, stall_cnt); end
    flush = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF || bubble_cnt !== 16'd5)
      begin errors++; $display("FAIL perf_saturate got stall=%h bub=%0d exp stall=ffff bub=5", stall_cnt, bubble_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
